// File: rtl/rescale_pkg.sv
// Shared defaults, FSM state encoding and divider iteration count for pixel_rescaler.
package rescale_pkg;

  localparam int unsigned NB_PIXEL_DEF = 19;
  localparam int unsigned NB_OUT_DEF   = 8;
  localparam int unsigned NB_COUNT_DEF = 32;

  // One quotient bit per divider iteration
  localparam int unsigned DIV_ITERS = NB_OUT_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DIV  = 2'd2,
    OUT  = 2'd3
  } state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring sequential divider: Q_W iterations, one quotient bit per cycle.
// The numerator must satisfy num < den * 2^Q_W so the quotient fits Q_W bits.
// done_o is high during the final iteration cycle; quot_o is complete after
// the following clock edge. A zero divisor yields a zero quotient.
module seq_divider
  import rescale_pkg::*;
#(
  parameter int unsigned DEN_W = NB_PIXEL_DEF + 1,
  parameter int unsigned Q_W   = DIV_ITERS
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [DEN_W+Q_W-1:0]   num_i,
  input  logic [DEN_W-1:0]       den_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [Q_W-1:0]         quot_o
);

  localparam int unsigned REM_W = DEN_W + 1;
  localparam int unsigned CNT_W = $clog2(Q_W + 1);

  logic [REM_W-1:0] rem_q, rem_d;
  logic [Q_W-1:0]   low_q, low_d;
  logic [Q_W-1:0]   quot_q, quot_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [REM_W-1:0] trial;

  // Load on start, otherwise shift in one numerator bit and trial-subtract
  always_comb begin
    rem_d  = rem_q;
    low_d  = low_q;
    quot_d = quot_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    trial  = {rem_q[REM_W-2:0], low_q[Q_W-1]};
    if (start_i) begin
      rem_d  = REM_W'(num_i[DEN_W+Q_W-1:Q_W]);
      low_d  = num_i[Q_W-1:0];
      den_d  = den_i;
      quot_d = '0;
      cnt_d  = CNT_W'(Q_W);
    end else if (cnt_q != '0) begin
      low_d = low_q << 1;
      cnt_d = cnt_q - CNT_W'(1);
      if ((den_q != '0) && (trial >= REM_W'(den_q))) begin
        rem_d  = trial - REM_W'(den_q);
        quot_d = Q_W'({quot_q, 1'b1});
      end else begin
        rem_d  = trial;
        quot_d = Q_W'({quot_q, 1'b0});
      end
    end
    busy_d = (cnt_d != '0);
    done_d = (cnt_d == CNT_W'(1));
  end

  // Divider state registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      low_q  <= '0;
      quot_q <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      low_q  <= low_d;
      quot_q <= quot_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = quot_q;

endmodule

// File: rtl/pixel_rescaler.sv
// Rescales signed convolution values into [0, 2^NB_OUT-1] using the frame
// min/max: pixel = floor((conv-min) * full_scale / (max-min)), clamped.
// Optional macro RESCALE_ROUND_EN: adds floor(range/2) to the numerator so the
// result rounds to nearest instead of truncating.
module pixel_rescaler
  import rescale_pkg::*;
#(
  parameter int unsigned NB_PIXEL = NB_PIXEL_DEF,
  parameter int unsigned NB_OUT   = NB_OUT_DEF,
  parameter int unsigned NB_COUNT = NB_COUNT_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic signed [NB_PIXEL-1:0] i_maxValue,
  input  logic signed [NB_PIXEL-1:0] i_minValue,
  input  logic                       i_endSignal,
  input  logic [NB_COUNT-1:0]        i_imageSize,
  input  logic                       i_valid,
  input  logic signed [NB_PIXEL-1:0] i_convValue,
  output logic                       o_ready,
  output logic [NB_OUT-1:0]          o_pixel,
  output logic                       o_valid,
  output logic                       o_done
);

  localparam int unsigned RNG_W = NB_PIXEL + 1;
  localparam int unsigned DIF_W = NB_PIXEL + 2;
  localparam int unsigned NUM_W = RNG_W + NB_OUT;

  state_e                      state_q, state_d;
  logic signed [NB_PIXEL-1:0]  min_q, min_d;
  logic [RNG_W-1:0]            range_q, range_d;
  logic [NB_COUNT-1:0]         size_q, size_d;
  logic [NB_COUNT-1:0]         count_q, count_d;
  logic                        ready_q, ready_d;
  logic                        valid_q, valid_d;
  logic                        done_q, done_d;
  logic                        div_start;
  logic                        div_busy;
  logic                        div_done;
  logic signed [DIF_W-1:0]     diff;
  logic [RNG_W-1:0]            opnd;
  logic [NUM_W-1:0]            num;

  // Clamp conv-min into [0, range] and form the scaled numerator
  always_comb begin
    diff = {{2{i_convValue[NB_PIXEL-1]}}, i_convValue} - {{2{min_q[NB_PIXEL-1]}}, min_q};
    if (diff[DIF_W-1]) begin
      opnd = '0;
    end else if (diff > {1'b0, range_q}) begin
      opnd = range_q;
    end else begin
      opnd = diff[RNG_W-1:0];
    end
    num = {opnd, {NB_OUT{1'b0}}} - NUM_W'(opnd);
`ifdef RESCALE_ROUND_EN
    num = num + NUM_W'(range_q >> 1);
`endif
  end

  // Frame/pixel control: next state and registered outputs
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    range_d   = range_q;
    size_d    = size_q;
    count_d   = count_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_endSignal) begin
          min_d   = i_minValue;
          range_d = {i_maxValue[NB_PIXEL-1], i_maxValue} - {i_minValue[NB_PIXEL-1], i_minValue};
          size_d  = i_imageSize;
          count_d = '0;
          if (i_imageSize == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (i_valid && ready_q) begin
          div_start = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: begin
        if (div_busy && div_done) begin
          state_d = OUT;
          valid_d = 1'b1;
          done_d  = ((count_q + NB_COUNT'(1)) == size_q);
        end
      end
      OUT: begin
        count_d = count_q + NB_COUNT'(1);
        state_d = (count_d == size_q) ? IDLE : RUN;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == RUN);
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      min_q   <= '0;
      range_q <= '0;
      size_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      range_q <= range_d;
      size_q  <= size_d;
      count_q <= count_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  seq_divider #(
    .DEN_W (RNG_W),
    .Q_W   (NB_OUT)
  ) u_div (
    .clk_i   (clock),
    .rst_ni  (reset),
    .start_i (div_start),
    .num_i   (num),
    .den_i   (range_q),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .quot_o  (o_pixel)
  );

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_pixel_rescaler.sv
// Directed + randomized bench for pixel_rescaler with an arithmetic reference model.
module tb_pixel_rescaler;
  import rescale_pkg::*;

  localparam int unsigned NBP = 19;
  localparam int unsigned NBO = 8;
  localparam int unsigned NBC = 32;

  logic                  clock;
  logic                  reset;
  logic signed [NBP-1:0] i_maxValue;
  logic signed [NBP-1:0] i_minValue;
  logic                  i_endSignal;
  logic [NBC-1:0]        i_imageSize;
  logic                  i_valid;
  logic signed [NBP-1:0] i_convValue;
  logic                  o_ready;
  logic [NBO-1:0]        o_pixel;
  logic                  o_valid;
  logic                  o_done;

  int checks   = 0;
  int failures = 0;
  int cur_min  = 0;
  int cur_max  = 0;
  int strm[3]     = '{-1, 49, 99};
`ifdef RESCALE_ROUND_EN
  int strm_exp[3] = '{0, 128, 255};
`else
  int strm_exp[3] = '{0, 127, 255};
`endif
  int idx, mn, mx, sz, cv;

  pixel_rescaler #(
    .NB_PIXEL (NBP),
    .NB_OUT   (NBO),
    .NB_COUNT (NBC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .i_maxValue  (i_maxValue),
    .i_minValue  (i_minValue),
    .i_endSignal (i_endSignal),
    .i_imageSize (i_imageSize),
    .i_valid     (i_valid),
    .i_convValue (i_convValue),
    .o_ready     (o_ready),
    .o_pixel     (o_pixel),
    .o_valid     (o_valid),
    .o_done      (o_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: clamp conv into [min,max], scale to full range with plain arithmetic
  function automatic int exp_pix(input int conv, input int lo, input int hi);
    longint rng, d;
    rng = longint'(hi) - longint'(lo);
    d   = longint'(conv) - longint'(lo);
    if (d < 0) d = 0;
    if (d > rng) d = rng;
    if (rng == 0) return 0;
`ifdef RESCALE_ROUND_EN
    return int'((d * 255 + rng / 2) / rng);
`else
    return int'((d * 255) / rng);
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input int lo, input int hi, input int n);
    cur_min     = lo;
    cur_max     = hi;
    i_minValue  = NBP'(lo);
    i_maxValue  = NBP'(hi);
    i_imageSize = NBC'(n);
    i_endSignal = 1'b1;
    @(negedge clock);
    i_endSignal = 1'b0;
  endtask

  // One transfer, then cycle-by-cycle checks through the output pulse
  task automatic do_pixel(input int conv, input bit last);
    int n;
    int ep;
    n  = 0;
    ep = exp_pix(conv, cur_min, cur_max);
    while (o_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("ready_before", 64'(o_ready), 64'(1));
    i_valid     = 1'b1;
    i_convValue = NBP'(conv);
    @(negedge clock);
    i_valid     = 1'b0;
    i_convValue = NBP'($urandom);
    for (int k = 1; k <= 9; k++) begin
      chk("ready_busy", 64'(o_ready), 64'(0));
      if (k < 9) begin
        chk("valid_early", 64'(o_valid), 64'(0));
        chk("done_early", 64'(o_done), 64'(0));
      end else begin
        chk("valid_lat9", 64'(o_valid), 64'(1));
        chk("pixel", 64'(o_pixel), 64'(ep));
        chk("done_last", 64'(o_done), 64'(last));
      end
      @(negedge clock);
    end
    chk("valid_pulse", 64'(o_valid), 64'(0));
    chk("done_pulse", 64'(o_done), 64'(0));
    chk("ready_after", 64'(o_ready), 64'(!last));
  endtask

  initial begin
    reset       = 1'b0;
    i_maxValue  = '0;
    i_minValue  = '0;
    i_endSignal = 1'b0;
    i_imageSize = '0;
    i_valid     = 1'b0;
    i_convValue = '0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_ready", 64'(o_ready), 64'(0));
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_done", 64'(o_done), 64'(0));
    chk("rst_pixel", 64'(o_pixel), 64'(0));
    chk("rst_state", 64'(dut.state_q), 64'(IDLE));
    reset = 1'b1;
    @(negedge clock);
    chk("idle_ready", 64'(o_ready), 64'(0));

    // Basic frame with i_valid held high: one transfer every 10 cycles
    start_frame(-1, 99, 3);
    i_valid = 1'b1;
    for (int c = 0; c < 34; c++) begin
      idx = (c / 10 > 2) ? 2 : c / 10;
      i_convValue = NBP'(strm[idx]);
      chk("hs_ready", 64'(o_ready), 64'((c % 10 == 0) && (c < 30)));
      chk("hs_valid", 64'(o_valid), 64'((c % 10 == 9) && (c < 30)));
      chk("hs_done", 64'(o_done), 64'(c == 29));
      if ((c % 10 == 9) && (c < 30)) begin
        chk("hs_pixel", 64'(o_pixel), 64'(strm_exp[idx]));
        chk("hs_model", 64'(o_pixel), 64'(exp_pix(strm[idx], -1, 99)));
      end
      @(negedge clock);
    end
    i_valid = 1'b0;

    // Clamping, with a stray end pulse during RUN that must be ignored
    start_frame(0, 100, 2);
    i_minValue  = NBP'(50);
    i_maxValue  = NBP'(60);
    i_imageSize = '0;
    i_endSignal = 1'b1;
    @(negedge clock);
    i_endSignal = 1'b0;
    chk("ign_ready", 64'(o_ready), 64'(1));
    chk("ign_done", 64'(o_done), 64'(0));
    do_pixel(200, 1'b0);
    do_pixel(-50, 1'b1);

    // Zero range
    start_frame(5, 5, 2);
    do_pixel(5, 1'b0);
    do_pixel(9, 1'b1);

    // Zero-size frame
    start_frame(3, 9, 0);
    chk("sz0_done", 64'(o_done), 64'(1));
    chk("sz0_valid", 64'(o_valid), 64'(0));
    chk("sz0_ready", 64'(o_ready), 64'(0));
    @(negedge clock);
    chk("sz0_done_off", 64'(o_done), 64'(0));
    chk("sz0_state", 64'(dut.state_q), 64'(IDLE));

    // Full signed range
    start_frame(-262144, 262143, 3);
    do_pixel(-262144, 1'b0);
    do_pixel(262143, 1'b0);
    do_pixel(0, 1'b1);

    // Random frames
    for (int f = 0; f < 4; f++) begin
      mn = int'($urandom_range(0, 400000)) - 200000;
      mx = mn + int'($urandom_range(0, 60000));
      sz = int'($urandom_range(1, 4));
      start_frame(mn, mx, sz);
      for (int p = 0; p < sz; p++) begin
        cv = mn - 1000 + int'($urandom_range(0, 32'(2000 + mx - mn)));
        do_pixel(cv, p == sz - 1);
      end
    end

    // Reset during DIV aborts silently
    start_frame(0, 100, 2);
    i_valid     = 1'b1;
    i_convValue = NBP'(50);
    @(negedge clock);
    i_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_ready", 64'(o_ready), 64'(0));
    chk("abort_valid", 64'(o_valid), 64'(0));
    chk("abort_done", 64'(o_done), 64'(0));
    chk("abort_pixel", 64'(o_pixel), 64'(0));
    chk("abort_state", 64'(dut.state_q), 64'(IDLE));
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk("abort_quiet_v", 64'(o_valid), 64'(0));
      chk("abort_quiet_d", 64'(o_done), 64'(0));
      chk("abort_quiet_r", 64'(o_ready), 64'(0));
      @(negedge clock);
    end

    // Recovery after abort
    start_frame(0, 10, 1);
    do_pixel(5, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_rescaler.md
PIXEL_RESCALER -- requirements
Module: pixel_rescaler

Interface
REQ-001 Parameter NB_PIXEL, default 19: signed width of convolution values and extremes.
REQ-002 Parameter NB_OUT, default 8: unsigned output pixel width; full scale is 2^NB_OUT-1 (255).
REQ-003 Parameter NB_COUNT, default 32: width of the pixel counter and the image size.
REQ-004 clock  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 i_maxValue  in  NB_PIXEL  signed frame maximum from the extreme-search stage.
REQ-007 i_minValue  in  NB_PIXEL  signed frame minimum from the extreme-search stage.
REQ-008 i_endSignal  in  1  extremes valid; sampled only in IDLE.
REQ-009 i_imageSize  in  NB_COUNT  number of pixels per frame; sampled with i_endSignal.
REQ-010 i_valid  in  1  i_convValue valid.
REQ-011 i_convValue  in  NB_PIXEL  signed convolution value to rescale.
REQ-012 o_ready  out  1  block accepts i_convValue this cycle.
REQ-013 o_pixel  out  NB_OUT  rescaled pixel; meaningful only while o_valid=1.
REQ-014 o_valid  out  1  one-cycle pulse per output pixel.
REQ-015 o_done  out  1  one-cycle pulse after the last pixel of a frame.

Function
REQ-016 States SHALL be IDLE, RUN, DIV and OUT.
- IDLE: o_ready=0. On i_endSignal=1, latch min, range=max-min (NB_PIXEL+1 bits) and image size; clear counter; go to RUN.
- If the latched size is 0: o_done pulses the next cycle and the state returns to IDLE.
REQ-017 RUN: o_ready=1. A transfer is i_valid&o_ready at a rising edge; it latches the operand and moves to DIV. i_endSignal is ignored in RUN/DIV/OUT.
REQ-018 Operand prep: d=conv-min.
- conv<min: d clamps to 0.
- conv>max: d clamps to range.
REQ-019 Result SHALL be floor(d*255/range) via an NB_OUT-iteration restoring divider. Numerator width is NB_PIXEL+1+NB_OUT bits; the quotient never exceeds 255.
REQ-020 range==0: result SHALL be 0; timing is unchanged.
REQ-021 Latency: transfer at edge N; DIV occupies NB_OUT cycles; OUT (o_valid=1) is the cycle after the last DIV cycle, i.e. 9 cycles after N for NB_OUT=8. o_ready=0 during DIV and OUT.
REQ-022 OUT increments the counter.
- Count == latched size: o_done=1 in the same cycle as the last o_valid; go to IDLE.
- Otherwise: go to RUN.
REQ-023 No output back-pressure; o_valid is never held for more than one cycle.

Reset
REQ-024 reset=0 at a rising edge SHALL force IDLE, o_ready=0, o_valid=0, o_done=0, o_pixel=0, counter=0, latched min/range/size=0.
REQ-025 Reset mid-DIV or mid-frame SHALL abort without emitting o_valid or o_done.

Configuration
REQ-026 Macro RESCALE_ROUND_EN.
- Defined: add floor(range/2) to the numerator, giving round-to-nearest.
- Undefined: truncation.
- Latency and clamping are identical in both cases.

Structure
REQ-027 Package rescale_pkg SHALL hold NB_PIXEL/NB_OUT/NB_COUNT defaults, the state enum and the divider iteration count.
REQ-028 Sub-module seq_divider (start/busy/done, restoring, NB_OUT iterations) SHALL perform the division; the FSM, clamping and counter stay in pixel_rescaler.

Verification
REQ-029 min=-1, max=99, size=3; conv -1, 49, 99 -> o_pixel 0, 127, 255 (128 for the middle pixel with RESCALE_ROUND_EN); o_done with the 3rd o_valid.
REQ-030 Clamp: min=0, max=100; conv -50 -> 0; conv 200 -> 255.
REQ-031 range 0: min=max=5; conv 5 -> 0, with o_valid exactly 9 cycles after the transfer.
REQ-032 Handshake: i_valid held high continuously -> one transfer per 10 cycles; o_ready low from the cycle after each transfer through OUT.
REQ-033 size=0 -> o_done the cycle after i_endSignal, no o_valid; i_endSignal pulsed during RUN -> ignored.
REQ-034 reset=0 asserted during DIV -> no o_valid/o_done; all outputs 0 the next cycle; state IDLE.
